regfile_write_queue: RTL
========================

Name: regfile_write_queue

Overview:
- Write-side driver for the 32x32 register file: accepts results from multi-cycle units, for example the multiply/divide unit and load returns.
- Buffers results in an in-order FIFO and issues one register-file write per cycle on the RegWrite/WriteRegNo/WriteData interface.
- Gives decode a pending-write lookup so it can stall on RAW hazards.
- Sits between the execution units and the register file write port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 32, result width; must match the register file data width.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- InValid  input  1  producer has a result.
- InReady  output  1  queue can accept a result this cycle.
- InRegNo  input  5  destination register number.
- InData  input  DATA_W  result value.
- Stall  input  1  write port is claimed by the main pipeline this cycle; do not issue.
- Flush  input  1  synchronous discard of all queued and in-flight writes.
- RegWrite  output  1  register file write enable.
- WriteRegNo  output  5  register file write address.
- WriteData  output  DATA_W  register file write data.
- LookupReg1  input  5  decode source register 1.
- LookupReg2  input  5  decode source register 2.
- Pending1  output  1  a write to LookupReg1 is outstanding.
- Pending2  output  1  a write to LookupReg2 is outstanding.
- Count  output  5  number of FIFO entries, excluding the output stage.

Behaviour:
- Reset (Reset=0, asynchronous): FIFO empty, read/write pointers 0, Count=0, RegWrite=0, WriteRegNo=0, WriteData=0, InReady=1. Outputs clear immediately, mid-write included; nothing is committed afterwards.
- Push:
  - A push occurs on an edge where InValid=1 and InReady=1.
  - InReady = (Count < DEPTH), from registered state only. It is not raised by a same-cycle pop, so a full queue with a simultaneous pop still refuses the push.
- $0 filter: a handshaked push with InRegNo=0 completes normally but is not enqueued; Count is unchanged.
- Output stage (registered):
  - On each edge, if Stall=0 and Count>0, the head entry is popped and loaded into the output stage: RegWrite=1, WriteRegNo/WriteData = head.
  - Otherwise RegWrite=0, and WriteRegNo/WriteData hold their last values.
  - RegWrite is high for exactly one cycle per committed entry.
- Latency:
  - Push into an empty queue at edge k, with Stall=0 at edge k+1: RegWrite=1 between edges k+1 and k+2. Minimum latency is 2 cycles.
  - There is no push-to-output bypass.
- Throughput: one write per cycle while Stall=0 and the FIFO is non-empty.
- Ordering: strict FIFO. Two writes to the same register are both issued in arrival order; there is no coalescing.
- Simultaneous push and pop: Count unchanged; both pointers advance.
- Pointers: modulo DEPTH, wrap without gaps. Count saturates logically at DEPTH and never exceeds it.
- Pending1/Pending2:
  - Combinational.
  - High if LookupRegN != 0 and it matches any valid FIFO entry or the output stage while RegWrite=1.
  - Always 0 for register 0.
- Flush:
  - Synchronous, with priority over push and pop in the same cycle.
  - Next state: FIFO empty, Count=0, RegWrite=0.
  - A push handshaked in the flush cycle is discarded.
  - InReady stays governed by the pre-flush Count during the flush cycle.
- Stall=1: the output stage shows RegWrite=0 the next cycle and the FIFO holds. Pushes are still accepted up to DEPTH.

Test Plan:
- Reset release, single push of (InRegNo=5, InData=0xDEADBEEF), Stall=0: InReady=1 and Count=0 after reset. Count=1 after the push edge, RegWrite=1 with WriteRegNo=5 and WriteData=0xDEADBEEF exactly one cycle later, then Count=0 and RegWrite=0.
- Stall=1 while pushing registers 1,2,3,4,7 (DEPTH=4): pushes 1–4 accepted; InReady=0 at Count=4, so 7 waits. Release Stall: writes 1,2,3,4 on four consecutive cycles, then 7, all in order.
- Push InRegNo=0 with data 0x1234: handshake completes, Count stays 0, RegWrite never asserts.
- Queue holds a write to register 9; LookupReg1=9, LookupReg2=0: Pending1=1, Pending2=0. Pending1 stays 1 through the RegWrite cycle and drops to 0 the cycle after.
- Full queue with Stall=0 and InValid=1: one pop per cycle. Count goes 4→3 with InReady=0 during the full cycle, and the push is accepted on the next cycle. Pointer wrap is exercised over 12 continuous writes, all data correct.
- Flush asserted with Count=3 and a concurrent push: next cycle Count=0, RegWrite=0, and none of the 4 entries is ever written. Async Reset pulsed during RegWrite=1: RegWrite drops immediately without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_write_queue.sv
// In-order write queue in front of the register file write port.
// Buffers multi-cycle results, issues one write per cycle and reports pending writes for RAW stalls.
module regfile_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_reg_no,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              reg_write,
    output logic [4:0]        write_reg_no,
    output logic [DATA_W-1:0] write_data,
    input  logic [4:0]        lookup_reg1,
    input  logic [4:0]        lookup_reg2,
    output logic              pending1,
    output logic              pending2,
    output logic [4:0]        count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [4:0]        count_q, count_d;
    logic              reg_write_q;
    logic [4:0]        write_reg_no_q;
    logic [DATA_W-1:0] write_data_q;

    logic [4:0]        reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic              push, pop;
    logic              hit1, hit2;
    logic [PTR_W-1:0]  idx;

    // Writes to $0 handshake normally but never occupy an entry.
    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid && in_ready && (in_reg_no != 5'd0) && !flush;
    assign pop      = !stall && (count_q != 5'd0) && !flush;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (pop && !push) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            reg_write_q    <= 1'b0;
            write_reg_no_q <= '0;
            write_data_q   <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            reg_write_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
                write_reg_no_q <= reg_mem[rd_ptr_q];
                write_data_q   <= data_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr_q]  <= in_reg_no;
            data_mem[wr_ptr_q] <= in_data;
        end
    end

    // Scan the occupied window starting at the read pointer.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (5'(i) < count_q) begin
                if (reg_mem[idx] == lookup_reg1) hit1 = 1'b1;
                if (reg_mem[idx] == lookup_reg2) hit2 = 1'b1;
            end
        end
    end

    assign pending1 = (lookup_reg1 != 5'd0) &&
                      (hit1 || (reg_write_q && (write_reg_no_q == lookup_reg1)));
    assign pending2 = (lookup_reg2 != 5'd0) &&
                      (hit2 || (reg_write_q && (write_reg_no_q == lookup_reg2)));

    assign reg_write    = reg_write_q;
    assign write_reg_no = write_reg_no_q;
    assign write_data   = write_data_q;
    assign count        = count_q;

endmodule
